// File: rtl/keycode_pkg.sv
//------------------------------------------------------------------------------
// Module   : keycode_pkg
// Purpose  : Shared event encodings, key constants and FSM state type for the
//            keycode event generator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package keycode_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_REPEAT  = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;

    localparam logic [7:0] KEY_NONE   = 8'h00;

    // One FIFO entry is {type, code}
    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DELAY      = 2'd1,
        ST_REPEAT     = 2'd2,
        ST_PEND_PRESS = 2'd3
    } kstate_e;

    function automatic logic [EV_W-1:0] pack_event(input logic [1:0] ev_type,
                                                   input logic [7:0] ev_code);
        return {ev_type, ev_code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/event_fifo.sv
//------------------------------------------------------------------------------
// Module   : event_fifo
// Purpose  : Small synchronous FIFO for key events. A push is accepted when
//            not full or when a pop happens on the same edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero while empty so outputs are clean after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/keycode_event_gen.sv
//------------------------------------------------------------------------------
// Module   : keycode_event_gen
// Purpose  : Filters the software-written keycode level and turns accepted
//            changes into PRESS / REPEAT / RELEASE events queued in a FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keycode_event_gen
    import keycode_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_RATE   = 6,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode_in,
    input  logic       tick,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic [1:0] ev_type,
    output logic [7:0] held_code,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int SW   = $clog2(STABLE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    // Stability filter state
    logic [7:0]    cand_q;
    logic [SW-1:0] scnt_q;
    logic [7:0]    stable_q;
    logic          commit;

    // Typematic FSM state
    kstate_e       state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [TW-1:0] tcnt_limit;

    // Event push request toward the FIFO
    logic            push_req;
    logic [1:0]      push_type;
    logic [7:0]      push_code;
    logic [EV_W-1:0] fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            drop;
    logic            overflow_q;

    // Commit on the STABLE_CYCLES-th equal sample of a value that differs from the held key
    assign commit = (keycode_in == cand_q) &&
                    (scnt_q == SW'(STABLE_CYCLES - 1)) &&
                    (cand_q != stable_q);

    // Candidate tracking and saturating run counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q   <= KEY_NONE;
            scnt_q   <= '0;
            stable_q <= KEY_NONE;
        end else begin
            if (keycode_in != cand_q) begin
                cand_q <= keycode_in;
                scnt_q <= SW'(1);
            end else if (scnt_q < SW'(STABLE_CYCLES)) begin
                scnt_q <= scnt_q + SW'(1);
            end
            if (commit) stable_q <= cand_q;
        end
    end

    assign tcnt_limit = (state_q == ST_DELAY) ? TW'(REPEAT_DELAY - 1)
                                              : TW'(REPEAT_RATE - 1);

    // FSM state and typematic counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state and event generation; a commit outranks a same-cycle tick
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        push_req  = 1'b0;
        push_type = EV_PRESS;
        push_code = KEY_NONE;
        case (state_q)
            ST_PEND_PRESS: begin
                // Second half of a direct key change: stable_q already holds the new key
                push_req  = 1'b1;
                push_type = EV_PRESS;
                push_code = stable_q;
                state_d   = ST_DELAY;
                tcnt_d    = '0;
            end
            default: begin
                if (commit) begin
                    push_req = 1'b1;
                    if (stable_q == KEY_NONE) begin
                        push_type = EV_PRESS;
                        push_code = cand_q;
                        state_d   = ST_DELAY;
                        tcnt_d    = '0;
                    end else if (cand_q == KEY_NONE) begin
                        push_type = EV_RELEASE;
                        push_code = stable_q;
                        state_d   = ST_IDLE;
                        tcnt_d    = '0;
                    end else begin
                        push_type = EV_RELEASE;
                        push_code = stable_q;
                        state_d   = ST_PEND_PRESS;
                    end
                end else if (tick && (state_q != ST_IDLE)) begin
                    if (tcnt_q == tcnt_limit) begin
                        push_req  = 1'b1;
                        push_type = EV_REPEAT;
                        push_code = stable_q;
                        state_d   = ST_REPEAT;
                        tcnt_d    = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
        endcase
    end

    assign pop  = !fifo_empty && ev_ready;
    assign drop = push_req && fifo_full && !pop;

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_event_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push_req),
        .data_i  (pack_event(push_type, push_code)),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign ev_valid  = !fifo_empty;
    assign ev_type   = fifo_head[9:8];
    assign ev_code   = fifo_head[7:0];
    assign held_code = stable_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire
